serial_adder: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 17 +
 rtl/serial_adder_full_adder_bit.sv | 28 ++
 rtl/serial_adder.sv | 136 +++++++++++++
 tb/tb_serial_adder.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: state encoding, width limit
// and the counter-width helper.
package serial_adder_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam int WIDTH_MAX = 32;

    // Bit counter counts 0..WIDTH-1; one spare bit keeps it from wrapping
    // before the terminal compare.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/serial_adder_full_adder_bit.sv
// One-bit full adder built from two half-adder cells and an OR gate.
// Used as the single datapath slice of serial_adder.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic s0;
    logic c0;
    logic c1;

    half_adder u_ha0 (.a(a),  .b(b),   .s(s0), .c(c0));
    half_adder u_ha1 (.a(s0), .b(cin), .s(s),  .c(c1));

    assign cout = c0 | c1;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, one result bit per clock, LSB first.
// Optional build macro SERIAL_ADDER_SUB_EN adds a 'sub' input selecting
// a - b (two's complement: invert b, carry-in 1); cout=1 then means no borrow.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = cnt_width(WIDTH);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] partial_q, partial_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             accept;
    logic             last_bit;
    logic             fa_s;
    logic             fa_cout;
    logic [WIDTH-1:0] b_in;
    logic             carry_in;

    assign accept   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign last_bit = (state_q == ST_SHIFT) && (cnt_q == CW'(WIDTH - 1));

`ifdef SERIAL_ADDER_SUB_EN
    assign b_in     = sub ? ~b : b;
    assign carry_in = sub;
`else
    assign b_in     = b;
    assign carry_in = 1'b0;
`endif

    full_adder_bit u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; DONE can re-accept directly for back-to-back adds
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_SHIFT;
            ST_SHIFT: if (last_bit) state_d = ST_DONE;
            ST_DONE:  state_d = start ? ST_SHIFT : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Status outputs decoded from the registered state
    always_comb begin
        busy = (state_q == ST_SHIFT);
        done = (state_q == ST_DONE);
    end

    // Datapath next values: capture on accept, shift one bit per SHIFT edge,
    // publish the result only on the edge leaving SHIFT
    always_comb begin
        a_d       = a_q;
        b_d       = b_q;
        partial_d = partial_q;
        carry_d   = carry_q;
        cnt_d     = cnt_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        if (accept) begin
            a_d       = a;
            b_d       = b_in;
            carry_d   = carry_in;
            cnt_d     = '0;
            partial_d = '0;
        end else if (state_q == ST_SHIFT) begin
            a_d                  = a_q >> 1;
            b_d                  = b_q >> 1;
            partial_d            = partial_q >> 1;
            partial_d[WIDTH-1]   = fa_s;
            carry_d              = fa_cout;
            cnt_d                = cnt_q + CW'(1);
            if (last_bit) begin
                sum_d  = partial_d;
                cout_d = fa_cout;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            partial_q <= '0;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
        end else begin
            a_q       <= a_d;
            b_q       <= b_d;
            partial_q <= partial_d;
            carry_q   <= carry_d;
            cnt_q     <= cnt_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an 8-bit instance for the main cases and
// a 1-bit instance for the minimum width.
module tb_serial_adder;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
`ifdef SERIAL_ADDER_SUB_EN
    logic         sub = 1'b0;
    logic         sub1 = 1'b0;
`endif
    logic         busy, done, cout;
    logic [W-1:0] sum;

    logic         start1 = 1'b0;
    logic [0:0]   a1 = '0;
    logic [0:0]   b1 = '0;
    logic         busy1, done1, cout1;
    logic [0:0]   sum1;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub1),
`endif
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands with start high for the accepting edge E0.
    task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic hold);
        a     = av;
        b     = bv;
        start = 1'b1;
        tick();
        if (!hold) start = 1'b0;
    endtask

    // Called just after E0: expect busy for W cycles, then the done cycle.
    task automatic check_run(input string tag, input logic [W-1:0] exp_sum, input logic exp_cout);
        int busy_cnt = 0;
        int done_early = 0;
        for (int i = 0; i < W; i++) begin
            if (busy === 1'b1) busy_cnt++;
            if (done !== 1'b0) done_early++;
            tick();
        end
        chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(W));
        chk({tag, "_done_early"}, 32'(done_early), 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        chk({tag, "_sum"}, 32'(sum), 32'(exp_sum));
        chk({tag, "_cout"}, {31'd0, cout}, {31'd0, exp_cout});
    endtask

    initial begin
        int seen_done;
        // Reset state
        #2;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Basic adds
        start_op(8'h0F, 8'h01, 1'b0);
        check_run("add_0f_01", 8'h10, 1'b0);
        tick();
        chk("idle_after_done", {30'd0, busy, done}, 32'd0);

        start_op(8'hFF, 8'h01, 1'b0);
        check_run("add_ff_01", 8'h00, 1'b1);
        tick();

        start_op(8'h00, 8'h00, 1'b0);
        check_run("add_00_00", 8'h00, 1'b0);
        tick();

        // start held during SHIFT with new operands: first result unaffected,
        // second add accepted at the DONE cycle
        start_op(8'h0F, 8'h01, 1'b1);
        a = 8'h55;
        b = 8'h55;
        check_run("hold_first", 8'h10, 1'b0);
        tick();
        start = 1'b0;
        chk("b2b_busy", {31'd0, busy}, 32'd1);
        chk("b2b_sum_held", 32'(sum), 32'h10);
        // check_run expects to be called just after E0, which is now
        begin
            int busy_cnt = 0;
            for (int i = 0; i < W; i++) begin
                if (busy === 1'b1) busy_cnt++;
                tick();
            end
            chk("b2b_busy_cycles", 32'(busy_cnt), 32'(W));
            chk("b2b_done", {31'd0, done}, 32'd1);
            chk("b2b_sum", 32'(sum), 32'hAA);
            chk("b2b_cout", {31'd0, cout}, 32'd0);
        end
        tick();

        // Async reset during SHIFT cycle 4
        start_op(8'h0F, 8'h01, 1'b0);
        tick();
        tick();
        tick();
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        chk("async_rst_sum", 32'(sum), 32'd0);
        chk("async_rst_cout", {31'd0, cout}, 32'd0);
        seen_done = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done !== 1'b0) seen_done++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < W + 2; i++) begin
            tick();
            if (done !== 1'b0) seen_done++;
        end
        chk("no_done_after_rst", 32'(seen_done), 32'd0);

        start_op(8'h80, 8'h80, 1'b0);
        check_run("add_80_80", 8'h00, 1'b1);
        tick();

`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b1;
        start_op(8'h05, 8'h07, 1'b0);
        sub = 1'b0;
        check_run("sub_05_07", 8'hFE, 1'b0);
        tick();
        sub = 1'b1;
        start_op(8'h07, 8'h05, 1'b0);
        sub = 1'b0;
        check_run("sub_07_05", 8'h02, 1'b1);
        tick();
`endif

        // WIDTH=1 instance: 1+1
        a1 = 1'b1;
        b1 = 1'b1;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("w1_busy", {30'd0, busy1, done1}, 32'd2);
        tick();
        chk("w1_done", {30'd0, busy1, done1}, 32'd1);
        chk("w1_sum", {31'd0, sum1}, 32'd0);
        chk("w1_cout", {31'd0, cout1}, 32'd1);
        tick();
        chk("w1_idle", {30'd0, busy1, done1}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
